// File: rtl/sensor_frame_tx_if.sv
// Byte handshake between the frame transmitter and the external uart_tx.
// Master drives tx_data/tx_start, slave answers with tx_ready.
interface sensor_frame_tx_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_ready;

  modport master (
    output tx_data,
    output tx_start,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_start,
    output tx_ready
  );
endinterface

// File: rtl/sensor_frame_tx.sv
// Lighthouse timestamp framer: sync, seq, payload, check byte to uart_tx.
// Define SENSOR_FRAME_CRC8_EN for a CRC-8/0x07 check byte instead of XOR.
module sensor_frame_tx #(
  parameter int N_SENSORS  = 3,
  parameter int N_ITER     = 2,
  parameter int TS_WIDTH   = 17,
  parameter int WORD_BYTES = 3,
  parameter int SYNC_BYTES = 3,
  parameter logic [7:0] SYNC_VALUE = 8'h00
) (
  input  logic clk_12MHz,
  input  logic rstn,
  input  logic data_availible,
  input  logic [N_SENSORS*N_ITER*TS_WIDTH-1:0] sensor_iterations,
  sensor_frame_tx_if.master tx,
  output logic reset_parser,
  output logic busy,
  output logic frame_done,
  output logic [7:0] seq_num,
  output logic [7:0] overrun_count
);

  localparam int N_WORDS = N_SENSORS * N_ITER;
  localparam int VW      = N_WORDS * TS_WIDTH;
  localparam int WB      = 8 * WORD_BYTES;
  localparam int PAY     = N_WORDS * WORD_BYTES;
  localparam int L       = SYNC_BYTES + 1 + PAY + 1;
  localparam int IW      = $clog2(L);

  if (TS_WIDTH > WB) begin : g_bad_ts
    $error("TS_WIDTH must be <= 8*WORD_BYTES");
  end
  if (SYNC_BYTES < 1) begin : g_bad_sync
    $error("SYNC_BYTES must be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RSTP, S_SEND, S_WAIT, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [VW-1:0]   cap_q, cap_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [7:0]      chk_q, chk_d;
  logic [7:0]      seq_q, seq_d;
  logic [7:0]      ovr_q, ovr_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_start_q, tx_start_d;
  logic            rstp_q, rstp_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [PAY*8-1:0] pay;
  logic [PAY*8-1:0] pay_sh;
  logic [IW-1:0]    p_off;
  logic [7:0]       cur;

  function automatic logic [7:0] fold(
    input logic [7:0] c,
    input logic [7:0] b
  );
`ifdef SENSOR_FRAME_CRC8_EN
    logic [7:0] r;
    r = c ^ b;
    for (int i = 0; i < 8; i++) begin
      r = r[7] ? ({r[6:0], 1'b0} ^ 8'h07) : {r[6:0], 1'b0};
    end
    return r;
`else
    return c ^ b;
`endif
  endfunction

  // Zero-extend each captured timestamp into its byte-aligned payload slot.
  always_comb begin
    pay = '0;
    for (int w = 0; w < N_WORDS; w++) begin
      pay[w*WB +: WB] = WB'(cap_q[w*TS_WIDTH +: TS_WIDTH]);
    end
  end

  // Select the frame byte addressed by the current index.
  always_comb begin
    p_off  = idx_q - IW'(SYNC_BYTES + 1);
    pay_sh = pay << {p_off, 3'b000};
    if (idx_q < IW'(SYNC_BYTES)) begin
      cur = SYNC_VALUE;
    end else if (idx_q == IW'(SYNC_BYTES)) begin
      cur = seq_q;
    end else if (idx_q < IW'(L - 1)) begin
      cur = pay_sh[PAY*8-1 -: 8];
    end else begin
      cur = chk_q;
    end
  end

  // Next-state, datapath updates and registered output strobes.
  always_comb begin
    state_d    = state_q;
    cap_d      = cap_q;
    idx_d      = idx_q;
    chk_d      = chk_q;
    seq_d      = seq_q;
    ovr_d      = ovr_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    rstp_d     = 1'b0;
    done_d     = 1'b0;
    if (data_availible && busy_q && ovr_q != 8'hFF) begin
      ovr_d = ovr_q + 8'd1;
    end
    unique case (state_q)
      S_IDLE: begin
        if (data_availible) state_d = S_LOAD;
      end
      S_LOAD: begin
        cap_d   = sensor_iterations;
        chk_d   = 8'h00;
        idx_d   = '0;
        rstp_d  = 1'b1;
        state_d = S_RSTP;
      end
      S_RSTP: begin
        state_d = S_SEND;
      end
      S_SEND: begin
        if (tx.tx_ready) begin
          tx_data_d  = cur;
          tx_start_d = 1'b1;
          if (idx_q >= IW'(SYNC_BYTES) && idx_q < IW'(L - 1)) begin
            chk_d = fold(chk_q, cur);
          end
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!tx.tx_ready) begin
          if (idx_q < IW'(L - 1)) begin
            idx_d   = idx_q + IW'(1);
            state_d = S_SEND;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (tx.tx_ready) begin
          done_d  = 1'b1;
          seq_d   = seq_q + 8'd1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and datapath registers; reset aborts any frame in flight.
  always_ff @(posedge clk_12MHz or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      cap_q      <= '0;
      idx_q      <= '0;
      chk_q      <= 8'h00;
      seq_q      <= 8'h00;
      ovr_q      <= 8'h00;
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
      rstp_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cap_q      <= cap_d;
      idx_q      <= idx_d;
      chk_q      <= chk_d;
      seq_q      <= seq_d;
      ovr_q      <= ovr_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      rstp_q     <= rstp_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign tx.tx_data    = tx_data_q;
  assign tx.tx_start   = tx_start_q;
  assign reset_parser  = rstp_q;
  assign busy          = busy_q;
  assign frame_done    = done_q;
  assign seq_num       = seq_q;
  assign overrun_count = ovr_q;

endmodule

// File: tb/tb_sensor_frame_tx.sv
// Scoreboard bench for sensor_frame_tx: default instance plus a
// 4x1x24-bit, 2-sync-byte instance, each with a simple uart_tx model.
module tb_sensor_frame_tx;
  localparam int W  = 3 * 2 * 17;
  localparam int W2 = 4 * 1 * 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn, da, da2, hold;
  logic [W-1:0] vec;
  logic [W2-1:0] vec2;
  logic rp, bsy, fd, rp2, bsy2, fd2;
  logic [7:0] seq, ovr, seq2, ovr2;

  sensor_frame_tx_if u ();
  sensor_frame_tx_if u2 ();

  sensor_frame_tx dut (
    .clk_12MHz(clk), .rstn(rstn), .data_availible(da),
    .sensor_iterations(vec), .tx(u.master),
    .reset_parser(rp), .busy(bsy), .frame_done(fd),
    .seq_num(seq), .overrun_count(ovr)
  );

  sensor_frame_tx #(
    .N_SENSORS(4), .N_ITER(1), .TS_WIDTH(24),
    .WORD_BYTES(3), .SYNC_BYTES(2), .SYNC_VALUE(8'h00)
  ) dut2 (
    .clk_12MHz(clk), .rstn(rstn), .data_availible(da2),
    .sensor_iterations(vec2), .tx(u2.master),
    .reset_parser(rp2), .busy(bsy2), .frame_done(fd2),
    .seq_num(seq2), .overrun_count(ovr2)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] q[$];
  logic [7:0] q2[$];
  int bytes_seen = 0;
  int rp_cnt = 0;
  int fd_cnt = 0;
  int fd2_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] fold(input logic [7:0] c,
                                      input logic [7:0] b);
`ifdef SENSOR_FRAME_CRC8_EN
    logic [7:0] r;
    r = c ^ b;
    for (int i = 0; i < 8; i++)
      if (r[7]) r = {r[6:0], 1'b0} ^ 8'h07;
      else r = {r[6:0], 1'b0};
    return r;
`else
    return c ^ b;
`endif
  endfunction

  // uart_tx models: ready drops the cycle after a start, back next cycle
  always @(posedge clk) begin
    if (!rstn) u.tx_ready <= 1'b1;
    else if (hold) u.tx_ready <= 1'b0;
    else u.tx_ready <= !u.tx_start;
  end
  always @(posedge clk) begin
    if (!rstn) u2.tx_ready <= 1'b1;
    else u2.tx_ready <= !u2.tx_start;
  end

  // monitors: pop expected bytes whenever a start is presented
  always @(negedge clk) begin
    if (u.tx_start === 1'b1) begin
      bytes_seen++;
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL extra_byte: got %0h expected none", u.tx_data);
      end else begin
        chk("byte", u.tx_data, q.pop_front());
      end
    end
    if (rp === 1'b1) rp_cnt++;
    if (fd === 1'b1) fd_cnt++;
  end
  always @(negedge clk) begin
    if (u2.tx_start === 1'b1) begin
      if (q2.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL extra_byte2: got %0h expected none", u2.tx_data);
      end else begin
        chk("byte2", u2.tx_data, q2.pop_front());
      end
    end
    if (fd2 === 1'b1) fd2_cnt++;
  end

  // hand frame: sensor0/iter0 = 1FFFF, everything else zero
  task automatic push_hand(input logic [7:0] s, input logic [7:0] cx);
    logic [7:0] b[23];
    logic [7:0] c;
    for (int i = 0; i < 23; i++) b[i] = 8'h00;
    b[3] = s;
    b[4] = 8'h01;
    b[5] = 8'hFF;
    b[6] = 8'hFF;
    c = cx;
`ifdef SENSOR_FRAME_CRC8_EN
    c = 8'h00;
    for (int i = 3; i < 22; i++) c = fold(c, b[i]);
`endif
    b[22] = c;
    for (int i = 0; i < 23; i++) q.push_back(b[i]);
  endtask

  task automatic push_model(input logic [W-1:0] v, input logic [7:0] s);
    logic [7:0] c;
    logic [23:0] e;
    for (int i = 0; i < 3; i++) q.push_back(8'h00);
    q.push_back(s);
    c = fold(8'h00, s);
    for (int w = 0; w < 6; w++) begin
      e = 24'(v[(5 - w) * 17 +: 17]);
      for (int k = 2; k >= 0; k--) begin
        q.push_back(e[k*8 +: 8]);
        c = fold(c, e[k*8 +: 8]);
      end
    end
    q.push_back(c);
  endtask

  task automatic launch(input logic [W-1:0] v);
    vec = v;
    @(negedge clk) da = 1'b1;
    @(negedge clk) da = 1'b0;
    @(negedge clk) vec = W'({$urandom(), $urandom(), $urandom(), $urandom()});
  endtask

  task automatic wait_done(input int d0, input string nm);
    for (int i = 0; i < 3000 && fd_cnt == d0; i++) @(posedge clk);
    if (fd_cnt == d0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got no frame_done expected one", nm);
    end
    @(negedge clk);
    chk({nm, "_q_empty"}, q.size(), 0);
  endtask

  logic [W-1:0] v1;
  logic [W-1:0] vr;
  logic [7:0] c2;
  int d0, k, b0, o0;

  initial begin
    rstn = 1'b0; da = 1'b0; da2 = 1'b0; hold = 1'b0;
    vec = '0; vec2 = '0;
    v1 = {17'h1FFFF, 85'd0};
    repeat (3) @(negedge clk);
    chk("rst_tx_start", u.tx_start, 0);
    chk("rst_tx_data", u.tx_data, 0);
    chk("rst_busy", bsy, 0);
    chk("rst_reset_parser", rp, 0);
    chk("rst_frame_done", fd, 0);
    chk("rst_seq", seq, 0);
    chk("rst_ovr", ovr, 0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // second instance: 2 sync, seq, 12 34 56 x4, check
    q2.push_back(8'h00); q2.push_back(8'h00); q2.push_back(8'h00);
    c2 = 8'h00;
`ifdef SENSOR_FRAME_CRC8_EN
    for (int i = 0; i < 4; i++) begin
      c2 = fold(c2, 8'h12); c2 = fold(c2, 8'h34); c2 = fold(c2, 8'h56);
    end
`endif
    for (int i = 0; i < 4; i++) begin
      q2.push_back(8'h12); q2.push_back(8'h34); q2.push_back(8'h56);
    end
    q2.push_back(c2);
    vec2 = {4{24'h123456}};
    @(negedge clk) da2 = 1'b1;
    @(negedge clk) da2 = 1'b0;
    for (int i = 0; i < 500 && fd2_cnt == 0; i++) @(posedge clk);
    @(negedge clk);
    chk("p2_frame_done", fd2_cnt, 1);
    chk("p2_q_empty", q2.size(), 0);
    chk("p2_seq", seq2, 1);

    // frame 1 with latency check
    push_hand(8'h00, 8'h01);
    d0 = fd_cnt;
    launch(v1);
    k = 2;
    while (u.tx_start !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("latency", k - 1, 3);
    wait_done(d0, "f1");
    chk("f1_reset_parser", rp_cnt, 1);
    chk("f1_frame_done", fd_cnt, 1);
    chk("f1_seq", seq, 1);

    push_hand(8'h01, 8'h00);
    d0 = fd_cnt; launch(v1); wait_done(d0, "f2");
    chk("f2_seq", seq, 2);
    push_hand(8'h02, 8'h03);
    d0 = fd_cnt; launch(v1); wait_done(d0, "f3");
    chk("f3_seq", seq, 3);

    for (int s = 3; s < 255; s++) begin
      vr = W'({$urandom(), $urandom(), $urandom(), $urandom()});
      push_model(vr, 8'(s));
      d0 = fd_cnt; launch(vr); wait_done(d0, "fr");
      chk("fr_seq", seq, (s + 1) & 8'hFF);
    end

    push_hand(8'hFF, 8'hFE);
    d0 = fd_cnt; launch(v1); wait_done(d0, "f255");
    chk("wrap_seq", seq, 0);
    chk("total_reset_parser", rp_cnt, 256);
    chk("total_frame_done", fd_cnt, 256);

    // four strobes mid-frame are dropped and counted
    push_hand(8'h00, 8'h01);
    d0 = fd_cnt; launch(v1);
    for (int i = 0; i < 4; i++) begin
      repeat (3) @(negedge clk);
      da = 1'b1;
      @(negedge clk) da = 1'b0;
    end
    wait_done(d0, "ovr4");
    b0 = bytes_seen;
    repeat (40) @(negedge clk);
    chk("ovr4_count", ovr, 4);
    chk("ovr4_idle", bsy, 0);
    chk("ovr4_no_extra", bytes_seen, b0);

    // stall in SEND and hammer the strobe past saturation
    hold = 1'b1;
    push_hand(8'h01, 8'h00);
    d0 = fd_cnt; launch(v1);
    repeat (5) @(negedge clk);
    chk("stall_busy", bsy, 1);
    da = 1'b1;
    repeat (300) @(negedge clk);
    da = 1'b0;
    @(negedge clk);
    chk("ovr_sat", ovr, 255);
    hold = 1'b0;
    wait_done(d0, "sat");
    chk("sat_seq", seq, 2);

    // reset mid-frame at byte index 10
    push_hand(8'h02, 8'h03);
    b0 = bytes_seen;
    launch(v1);
    for (int i = 0; i < 500 && bytes_seen < b0 + 10; i++) @(posedge clk);
    chk("mid_bytes", bytes_seen - b0, 10);
    #2 rstn = 1'b0;
    #1;
    chk("mid_tx_start", u.tx_start, 0);
    chk("mid_tx_data", u.tx_data, 0);
    chk("mid_busy", bsy, 0);
    chk("mid_seq", seq, 0);
    chk("mid_ovr", ovr, 0);
    chk("mid_frame_done", fd, 0);
    chk("mid_reset_parser", rp, 0);
    q.delete();
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("mid_no_restart", bytes_seen - b0, 10);

    // all-zero frame with seq 0: check byte 00 for XOR and CRC
    for (int i = 0; i < 23; i++) q.push_back(8'h00);
    b0 = bytes_seen;
    d0 = fd_cnt; launch('0); wait_done(d0, "zero");
    chk("zero_len", bytes_seen - b0, 23);
    chk("zero_seq", seq, 1);
    chk("zero_ovr", ovr, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
